// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
// No logic, no latency; imported by the RX path and reusable by the TX side.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_bit_cyc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FWFT FIFO with registered head: a push into an empty FIFO is visible next cycle.
// Push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [AW:0]      remain;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push_ok, pop_ok;

  assign full     = (level_q == (AW+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign head_dat = head_q;

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    level_d  = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    remain   = level_q - (AW+1)'(pop_ok);
    head_d   = head_q;
    // Entries already stored take priority; only an otherwise-empty FIFO loads the new byte.
    if (remain != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (push_ok) begin
      head_d = push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/uart_rx_byte_stream.sv
// 8N1 UART receiver into a FWFT byte FIFO, presented as a valid/ready byte source.
// Byte valid one cycle after the stop-bit sample; when full and not popped, the byte is dropped and overrun pulses.
module uart_rx_byte_stream #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset,
  input  logic                          uart_rxd,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [7:0]                    out_data,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import uart_pkg::*;

  localparam int BIT_CYC  = calc_bit_cyc(CLK_HZ, BAUD);
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

  rx_state_e   state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        rxs_q, rxs_d;
  logic        rxs_dly_q, rxs_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        push, pop;
  logic        fifo_full, fifo_empty;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_comb begin
    sync1_d     = uart_rxd;
    rxs_d       = sync1_q;
    rxs_dly_d   = rxs_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (rxs_dly_q && !rxs_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Mid-start-bit recheck rejects short glitches silently.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs_q;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_BREAK: begin
        if (rxs_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    overrun_d = push && fifo_full && !pop;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_dly_q   <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      rxs_dly_q   <= rxs_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .push     (push),
    .push_dat (shift_q),
    .pop      (pop),
    .head_dat (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_byte_stream.sv
// Directed bench for uart_rx_byte_stream at 12 MHz / 115200 baud, 16-entry FIFO.
module tb_uart_rx_byte_stream;
  localparam int BIT = 104;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       frame_err;
  logic       overrun;
  logic [4:0] fifo_level;

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] rx_log [0:255];
  int rx_n = 0, fe_n = 0, ov_n = 0, both_n = 0, vld_cyc = 0, last_pop_cyc = 0;

  uart_rx_byte_stream #(
    .CLK_HZ     (12000000),
    .BAUD       (115200),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .uart_rxd    (uart_rxd),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .fifo_level  (fifo_level)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) cyc++;

  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (out_valid) vld_cyc++;
      if (out_valid && out_ready) begin
        rx_log[rx_n[7:0]] = out_data;
        rx_n++;
        last_pop_cyc = cyc;
      end
      if (frame_err) fe_n++;
      if (overrun) ov_n++;
      if (frame_err && overrun) both_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    tick(BIT);
  endtask

  // Leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset;
    reset_reset = 1'b1;
    tick(3);
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", out_data); end
    tests_run++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got fe=%b ov=%b want 0 0", frame_err, overrun);
    end
    tests_run++;
    if (fifo_level !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    reset_reset = 1'b0;
    tick(BIT);
  endtask

  task automatic test_single;
    int r0, f0, o0, v0, c0, lat;
    r0 = rx_n; f0 = fe_n; o0 = ov_n; v0 = vld_cyc;
    out_ready = 1'b1;
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    tick(50);
    lat = last_pop_cyc - c0;
    tests_run++;
    if (rx_n - r0 != 1) begin fails++; $display("FAIL single_count: got %0d want 1", rx_n - r0); end
    tests_run++;
    if (rx_log[r0[7:0]] !== 8'hA5) begin fails++; $display("FAIL single_data: got %h want a5", rx_log[r0[7:0]]); end
    tests_run++;
    if (vld_cyc - v0 != 1) begin fails++; $display("FAIL single_valid_cycles: got %0d want 1", vld_cyc - v0); end
    tests_run++;
    if (lat < 985 || lat > 995) begin fails++; $display("FAIL single_latency: got %0d want 985..995", lat); end
    tests_run++;
    if (fe_n != f0 || ov_n != o0) begin
      fails++; $display("FAIL single_flags: got fe=%0d ov=%0d want 0 0", fe_n - f0, ov_n - o0);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    tick(20);
    tests_run++;
    if (fifo_level !== 5'd3) begin fails++; $display("FAIL b2b_level: got %0d want 3", fifo_level); end
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      fails++; $display("FAIL b2b_head: got v=%b d=%h want 1 00", out_valid, out_data);
    end
    tick(10);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin
      fails++; $display("FAIL b2b_hold: got v=%b d=%h want 1 00", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(negedge clk_clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h00) begin fails++; $display("FAIL b2b_pop0: got v=%b d=%h want 1 00", out_valid, out_data); end
    @(negedge clk_clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF) begin fails++; $display("FAIL b2b_pop1: got v=%b d=%h want 1 ff", out_valid, out_data); end
    @(negedge clk_clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 8'h55) begin fails++; $display("FAIL b2b_pop2: got v=%b d=%h want 1 55", out_valid, out_data); end
    @(negedge clk_clk);
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got v=%b want 0", out_valid); end
    tick(2);
  endtask

  task automatic test_overrun;
    int o0, r0, idx;
    logic [7:0] b;
    out_ready = 1'b0;
    o0 = ov_n;
    for (int i = 1; i <= 16; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
    end
    tick(20);
    tests_run++;
    if (fifo_level !== 5'd16) begin fails++; $display("FAIL ovr_level16: got %0d want 16", fifo_level); end
    tests_run++;
    if (ov_n != o0) begin fails++; $display("FAIL ovr_early: got %0d pulses want 0", ov_n - o0); end
    send_frame(8'h11, 1'b1);
    tick(20);
    tests_run++;
    if (ov_n - o0 != 1) begin fails++; $display("FAIL ovr_pulse: got %0d pulses want 1", ov_n - o0); end
    tests_run++;
    if (fifo_level !== 5'd16) begin fails++; $display("FAIL ovr_level_after: got %0d want 16", fifo_level); end
    r0 = rx_n;
    out_ready = 1'b1;
    tick(30);
    tests_run++;
    if (rx_n - r0 != 16) begin fails++; $display("FAIL ovr_drain_count: got %0d want 16", rx_n - r0); end
    for (int i = 0; i < 16; i++) begin
      idx = r0 + i;
      b = 8'(i + 1);
      tests_run++;
      if (rx_log[idx[7:0]] !== b) begin fails++; $display("FAIL ovr_drain_byte%0d: got %h want %h", i, rx_log[idx[7:0]], b); end
    end
    tests_run++;
    if (fifo_level !== 5'd0) begin fails++; $display("FAIL ovr_drained_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_frame_err;
    int r0, f0, o0;
    r0 = rx_n; f0 = fe_n; o0 = ov_n;
    out_ready = 1'b1;
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    send_frame(8'h3C, 1'b1);
    tick(50);
    tests_run++;
    if (fe_n - f0 != 1) begin fails++; $display("FAIL ferr_pulses: got %0d want 1", fe_n - f0); end
    tests_run++;
    if (rx_n - r0 != 1) begin fails++; $display("FAIL ferr_count: got %0d want 1", rx_n - r0); end
    tests_run++;
    if (rx_log[r0[7:0]] !== 8'h3C) begin fails++; $display("FAIL ferr_data: got %h want 3c", rx_log[r0[7:0]]); end
    tests_run++;
    if (ov_n != o0 || both_n != 0) begin fails++; $display("FAIL ferr_other_flags: got ov=%0d both=%0d want 0 0", ov_n - o0, both_n); end
  endtask

  task automatic test_glitch;
    int r0, f0, o0;
    r0 = rx_n; f0 = fe_n; o0 = ov_n;
    out_ready = 1'b1;
    uart_rxd = 1'b0;
    tick(31);
    uart_rxd = 1'b1;
    tick(2 * BIT);
    tests_run++;
    if (rx_n != r0 || fifo_level !== 5'd0) begin fails++; $display("FAIL glitch_byte: got %0d bytes lvl %0d want 0 0", rx_n - r0, fifo_level); end
    tests_run++;
    if (fe_n != f0 || ov_n != o0) begin fails++; $display("FAIL glitch_flags: got fe=%0d ov=%0d want 0 0", fe_n - f0, ov_n - o0); end
    send_frame(8'h5A, 1'b1);
    tick(50);
    tests_run++;
    if (rx_n - r0 != 1 || rx_log[r0[7:0]] !== 8'h5A) begin
      fails++; $display("FAIL glitch_recover: got n=%0d d=%h want 1 5a", rx_n - r0, rx_log[r0[7:0]]);
    end
  endtask

  task automatic test_reset_mid;
    int r0, f0, o0;
    logic [7:0] b;
    b = 8'hF3;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(20);
    tests_run++;
    if (fifo_level !== 5'd2) begin fails++; $display("FAIL rmid_pre_level: got %0d want 2", fifo_level); end
    r0 = rx_n; f0 = fe_n; o0 = ov_n;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    uart_rxd = b[4];
    tick(BIT / 2);
    reset_reset = 1'b1;
    tick(1);
    reset_reset = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin
      fails++; $display("FAIL rmid_cleared: got v=%b lvl=%0d want 0 0", out_valid, fifo_level);
    end
    tick(BIT / 2);
    for (int i = 5; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
    tick(BIT);
    tests_run++;
    if (fifo_level !== 5'd0 || fe_n != f0 || ov_n != o0) begin
      fails++; $display("FAIL rmid_abandon: got lvl=%0d fe=%0d ov=%0d want 0 0 0", fifo_level, fe_n - f0, ov_n - o0);
    end
    out_ready = 1'b1;
    send_frame(8'h7E, 1'b1);
    tick(50);
    tests_run++;
    if (rx_n - r0 != 1 || rx_log[r0[7:0]] !== 8'h7E) begin
      fails++; $display("FAIL rmid_next: got n=%0d d=%h want 1 7e", rx_n - r0, rx_log[r0[7:0]]);
    end
  endtask

  initial begin
    tick(2);
    test_reset;
    test_single;
    test_back_to_back;
    test_overrun;
    test_frame_err;
    test_glitch;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
